sync_fifo_flex: RTL and testbench
=================================

SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=4).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold in entries (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in entries (1..DEPTH-1, < AF_LEVEL).
REQ-005 SHALL have parameter FWFT, default 0, read mode (0 = standard registered read, 1 = first-word-fall-through).
REQ-006 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port wr_en, input, 1, write request.
REQ-009 SHALL have port wdata, input, WIDTH, write data.
REQ-010 SHALL have port rd_en, input, 1, read request (acknowledge in FWFT mode).
REQ-011 SHALL have port rdata, output, WIDTH, read data.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty, output, 1 each, status flags.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy 0..DEPTH.
REQ-014 SHALL have ports wr_err, rd_err, output, 1 each, overflow / underflow error pulses.

Function
REQ-015 SHALL use write/read pointers of $clog2(DEPTH)+1 bits; low bits address memory, MSB is the wrap bit; pointers increment modulo 2*DEPTH.
REQ-016 SHALL accept a write iff wr_en=1 and full=0 at the clock edge: mem[wr_ptr]<=wdata, wr_ptr+1.
REQ-017 SHALL accept a read iff rd_en=1 and empty=0 at the clock edge: rd_ptr+1.
REQ-018 SHALL evaluate acceptance against flags present before the edge; simultaneous accepted read and write leave count unchanged.
REQ-019 SHALL, when full and wr_en=rd_en=1: accept read, reject write; when empty and wr_en=rd_en=1: accept write, reject read.
REQ-020 SHALL compute count = wr_ptr - rd_ptr (mod 2*DEPTH), empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL), all from registered state; flags reflect an operation in the cycle after its edge.
REQ-021 SHALL, with FWFT=0, register rdata <= mem[rd_ptr] on an accepted read, valid the cycle after the edge; rdata holds its value otherwise.
REQ-022 SHALL, with FWFT=1, drive rdata = mem[rd_ptr] combinationally; rdata valid whenever empty=0; rd_en pops the displayed word; rdata undefined-but-stable-per-memory when empty.
REQ-023 SHALL assert wr_err for exactly one cycle following an edge where wr_en=1 and the write was rejected; likewise rd_err for a rejected read; both registered, otherwise 0.
REQ-024 SHALL never modify memory, pointers or count on a rejected request.
REQ-025 SHALL write the same address a read is sourcing only when FIFO is not empty-and-full ambiguous; read-during-write to the same entry never occurs since accepted write targets a free entry.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, wr_err=rd_err=0, rdata=0 (FWFT=0).
REQ-027 SHALL give rst priority over wr_en/rd_en in the same cycle; requests during reset are discarded with no error pulse.
REQ-028 SHALL NOT clear memory contents on reset; reset mid-operation discards all stored data.

Verification
REQ-029 Reset, then write 0x01..0x10 (16 writes, defaults) -> almost_full high after 14th, full high after 16th, count=16, empty=0, no wr_err.
REQ-030 Full FIFO, write 0xAA -> wr_err high one cycle, count stays 16, subsequent 16 reads return 0x01..0x10 in order (0xAA never appears).
REQ-031 Empty FIFO, rd_en=1 -> rd_err high one cycle, rdata unchanged, count=0; FWFT=0 read of stored 0x55 -> rdata=0x55 exactly one cycle after edge.
REQ-032 Full FIFO, wr_en=rd_en=1 with wdata=0x77 -> read accepted, wr_err=1, count=15; empty FIFO same stimulus -> write accepted, rd_err=1, count=1.
REQ-033 Steady wr_en=rd_en=1 at count=8 for 40 cycles -> count stays 8, pointers wrap past 2*DEPTH, data order preserved, no errors.
REQ-034 FWFT=1: write 0x3C into empty FIFO -> empty=0 and rdata=0x3C next cycle with rd_en=0; rd_en pulse -> empty=1; rst asserted at count=5 -> count=0, empty=1 next cycle.

Source files
------------

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with wrap-bit pointers, threshold flags, registered error
// pulses and a choice of registered or first-word-fall-through read data.
module sync_fifo_flex #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wr_err,
  output logic                     rd_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             wr_err_q, wr_err_d;
  logic             rd_err_q, rd_err_d;
  logic             wr_accept, rd_accept;
  logic [WIDTH-1:0] mem [DEPTH];

  // Flags come only from registered pointers, so acceptance is judged on
  // the state that existed before the edge.
  always_comb begin
    count        = wr_ptr_q - rd_ptr_q;
    empty        = (count == '0);
    full         = (count == PW'(DEPTH));
    almost_full  = (count >= PW'(AF_LEVEL));
    almost_empty = (count <= PW'(AE_LEVEL));
    wr_accept    = wr_en && !full && !rst;
    rd_accept    = rd_en && !empty && !rst;
    wr_ptr_d     = wr_ptr_q + PW'(wr_accept);
    rd_ptr_d     = rd_ptr_q + PW'(rd_accept);
    wr_err_d     = wr_en && full;
    rd_err_d     = rd_en && empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;

  if (FWFT != 0) begin : g_fwft
    assign rdata = mem[rd_ptr_q[AW-1:0]];
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (rd_accept) rdata_d = mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a registered-read and an FWFT instance, each
// compared cycle by cycle against a queue-based reference model.
module tb_sync_fifo_flex;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b0, we0 = 1'b0, re0 = 1'b0;
  logic [7:0] wd0 = '0, rdata0;
  logic       full0, empty0, af0, ae0, wer0, rer0;
  logic [4:0] cnt0;

  logic       rst1 = 1'b0, we1 = 1'b0, re1 = 1'b0;
  logic [7:0] wd1 = '0, rdata1;
  logic       full1, empty1, af1, ae1, wer1, rer1;
  logic [4:0] cnt1;

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst0), .wr_en(we0), .wdata(wd0), .rd_en(re0), .rdata(rdata0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .wr_err(wer0), .rd_err(rer0));

  sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .wr_en(we1), .wdata(wd1), .rd_en(re1), .rdata(rdata1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .wr_err(wer1), .rd_err(rer1));

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_rd0 = '0;
  logic       ewe0 = 1'b0, ere0 = 1'b0, ewe1 = 1'b0, ere1 = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  // Expected {full, empty, almost_full, almost_empty, wr_err, rd_err, count}
  function automatic logic [10:0] exp_stat(int n, logic we_err, logic re_err);
    return {n == D, n == 0, n >= AF, n <= AE, we_err, re_err, 5'(n)};
  endfunction

  task automatic cyc0(input logic we, input logic re, input logic [7:0] wd);
    we0 = we; re0 = re; wd0 = wd;
    @(posedge clk);
    ewe0 = we && (q0.size() == D);
    ere0 = re && (q0.size() == 0);
    if (re && q0.size() > 0) exp_rd0 = q0.pop_front();
    if (we && !ewe0) q0.push_back(wd);
    #1;
    we0 = 1'b0; re0 = 1'b0;
  endtask

  task automatic cyc1(input logic we, input logic re, input logic [7:0] wd);
    we1 = we; re1 = re; wd1 = wd;
    @(posedge clk);
    ewe1 = we && (q1.size() == D);
    ere1 = re && (q1.size() == 0);
    if (re && q1.size() > 0) void'(q1.pop_front());
    if (we && !ewe1) q1.push_back(wd);
    #1;
    we1 = 1'b0; re1 = 1'b0;
  endtask

  // Reset with requests pending: they must be dropped silently.
  task automatic reset0();
    rst0 = 1'b1; we0 = 1'b1; re0 = 1'b1; wd0 = 8'hEE;
    @(posedge clk);
    q0.delete(); exp_rd0 = '0; ewe0 = 1'b0; ere0 = 1'b0;
    #1;
    rst0 = 1'b0; we0 = 1'b0; re0 = 1'b0;
  endtask

  task automatic reset1();
    rst1 = 1'b1; we1 = 1'b1; re1 = 1'b1; wd1 = 8'hEE;
    @(posedge clk);
    q1.delete(); ewe1 = 1'b0; ere1 = 1'b0;
    #1;
    rst1 = 1'b0; we1 = 1'b0; re1 = 1'b0;
  endtask

  task automatic test_reset();
    cyc0(1'b1, 1'b0, 8'h99);
    reset0();
    n_total++;
    if ({full0, empty0, af0, ae0, wer0, rer0, cnt0, rdata0} !== {4'b0101, 2'b00, 5'd0, 8'h00})
      $display("FAIL reset_state got %b exp %b",
               {full0, empty0, af0, ae0, wer0, rer0, cnt0, rdata0}, {4'b0101, 2'b00, 5'd0, 8'h00});
    else n_pass++;
    cyc0(1'b0, 1'b0, 8'h00);
    n_total++;
    if ({wer0, rer0, cnt0} !== 7'd0)
      $display("FAIL reset_no_err got %b exp %b", {wer0, rer0, cnt0}, 7'd0);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      cyc0(1'b1, 1'b0, 8'(i));
      n_total++;
      if ({full0, empty0, af0, ae0, wer0, rer0, cnt0} !== exp_stat(q0.size(), ewe0, ere0))
        $display("FAIL fill_stat%0d got %b exp %b", i,
                 {full0, empty0, af0, ae0, wer0, rer0, cnt0}, exp_stat(q0.size(), ewe0, ere0));
      else n_pass++;
    end
    n_total++;
    if ({full0, af0, cnt0} !== {2'b11, 5'd16})
      $display("FAIL fill_full got %b exp %b", {full0, af0, cnt0}, {2'b11, 5'd16});
    else n_pass++;
  endtask

  task automatic test_overflow();
    cyc0(1'b1, 1'b0, 8'hAA);
    n_total++;
    if ({wer0, cnt0} !== {1'b1, 5'd16})
      $display("FAIL ovf_err got %b exp %b", {wer0, cnt0}, {1'b1, 5'd16});
    else n_pass++;
    cyc0(1'b0, 1'b0, 8'h00);
    n_total++;
    if (wer0 !== 1'b0) $display("FAIL ovf_pulse got %b exp 0", wer0);
    else n_pass++;
    for (int i = 1; i <= D; i++) begin
      cyc0(1'b0, 1'b1, 8'h00);
      n_total++;
      if (rdata0 !== 8'(i) || rdata0 !== exp_rd0)
        $display("FAIL ovf_read%0d got %h exp %h", i, rdata0, 8'(i));
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    cyc0(1'b0, 1'b1, 8'h00);
    n_total++;
    if ({rer0, cnt0, rdata0} !== {1'b1, 5'd0, 8'h10})
      $display("FAIL udf_err got %b exp %b", {rer0, cnt0, rdata0}, {1'b1, 5'd0, 8'h10});
    else n_pass++;
    cyc0(1'b1, 1'b0, 8'h55);
    n_total++;
    if ({rer0, cnt0, rdata0} !== {1'b0, 5'd1, 8'h10})
      $display("FAIL udf_write got %b exp %b", {rer0, cnt0, rdata0}, {1'b0, 5'd1, 8'h10});
    else n_pass++;
    cyc0(1'b0, 1'b1, 8'h00);
    n_total++;
    if ({rdata0, empty0} !== {8'h55, 1'b1})
      $display("FAIL udf_read55 got %h exp 55", rdata0);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < D; i++) cyc0(1'b1, 1'b0, 8'($urandom));
    cyc0(1'b1, 1'b1, 8'h77);
    n_total++;
    if ({wer0, rer0, cnt0, rdata0} !== {2'b10, 5'd15, exp_rd0} || ewe0 !== 1'b1)
      $display("FAIL simul_full got %b exp %b", {wer0, rer0, cnt0, rdata0}, {2'b10, 5'd15, exp_rd0});
    else n_pass++;
    while (q0.size() > 0) cyc0(1'b0, 1'b1, 8'h00);
    cyc0(1'b1, 1'b1, 8'h77);
    n_total++;
    if ({wer0, rer0, cnt0} !== {2'b01, 5'd1})
      $display("FAIL simul_empty got %b exp %b", {wer0, rer0, cnt0}, {2'b01, 5'd1});
    else n_pass++;
    cyc0(1'b0, 1'b1, 8'h00);
    n_total++;
    if (rdata0 !== 8'h77) $display("FAIL simul_data got %h exp 77", rdata0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    reset0();
    for (int i = 0; i < 8; i++) cyc0(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      cyc0(1'b1, 1'b1, 8'($urandom));
      n_total++;
      if ({full0, empty0, af0, ae0, wer0, rer0, cnt0, rdata0} !==
          {exp_stat(q0.size(), ewe0, ere0), exp_rd0} || q0.size() != 8)
        $display("FAIL b2b%0d got %b exp %b", i, {full0, empty0, af0, ae0, wer0, rer0, cnt0, rdata0},
                 {exp_stat(q0.size(), ewe0, ere0), exp_rd0});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    reset0();
    for (int i = 0; i < 400; i++) begin
      logic we, re;
      we = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      re = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc0(we, re, 8'($urandom));
      n_total++;
      if ({full0, empty0, af0, ae0, wer0, rer0, cnt0, rdata0} !==
          {exp_stat(q0.size(), ewe0, ere0), exp_rd0})
        $display("FAIL rand%0d got %b exp %b", i, {full0, empty0, af0, ae0, wer0, rer0, cnt0, rdata0},
                 {exp_stat(q0.size(), ewe0, ere0), exp_rd0});
      else n_pass++;
    end
  endtask

  task automatic test_fwft();
    reset1();
    cyc1(1'b1, 1'b0, 8'h3C);
    n_total++;
    if ({empty1, rdata1} !== {1'b0, 8'h3C})
      $display("FAIL fwft_show got %b/%h exp 0/3c", empty1, rdata1);
    else n_pass++;
    cyc1(1'b0, 1'b1, 8'h00);
    n_total++;
    if ({empty1, cnt1} !== {1'b1, 5'd0})
      $display("FAIL fwft_pop got %b exp %b", {empty1, cnt1}, {1'b1, 5'd0});
    else n_pass++;
    for (int i = 0; i < 300; i++) begin
      cyc1(($urandom_range(0, 2) != 0) && (i < 150 || $urandom_range(0, 2) == 0),
           $urandom_range(0, 1) == 1, 8'($urandom));
      n_total++;
      if ({full1, empty1, af1, ae1, wer1, rer1, cnt1} !== exp_stat(q1.size(), ewe1, ere1) ||
          (q1.size() > 0 && rdata1 !== q1[0]))
        $display("FAIL fwft_rand%0d got %b/%h exp %b/%h", i, {full1, empty1, af1, ae1, wer1, rer1, cnt1},
                 rdata1, exp_stat(q1.size(), ewe1, ere1), (q1.size() > 0) ? q1[0] : 8'h00);
      else n_pass++;
    end
    reset1();
    for (int i = 0; i < 5; i++) cyc1(1'b1, 1'b0, 8'($urandom));
    n_total++;
    if (cnt1 !== 5'd5) $display("FAIL fwft_cnt5 got %0d exp 5", cnt1);
    else n_pass++;
    reset1();
    n_total++;
    if ({empty1, cnt1, wer1, rer1} !== {1'b1, 5'd0, 2'b00})
      $display("FAIL fwft_rst got %b exp %b", {empty1, cnt1, wer1, rer1}, {1'b1, 5'd0, 2'b00});
    else n_pass++;
  endtask

  initial begin
    reset1();
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_fwft();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
